// File: rtl/restoring_div_param.sv
// Iterative restoring divider: one quotient bit per clock, unsigned or two's-complement
// operands selected per operation, with divide-by-zero detection and a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | one restoring iteration per clock, WIDTH iterations
// FIX   | apply sign correction, publish results, pulse done
// DZ    | divisor was zero: publish all-ones quotient and raw dividend
module restoring_div_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] divident,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DZ} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] dvd_q;
  logic             qneg;
  logic             rneg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             under;

  // Magnitude kept as an unsigned WIDTH-bit value so the most-negative operand stays exact.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sm);
    return (sm && v[WIDTH-1]) ? -v : v;
  endfunction

  // Remainder is always below the divisor, so the difference fits in WIDTH bits when kept.
  assign shifted = {p_q, a_q[WIDTH-1]};
  assign under   = shifted < {1'b0, d_q};
  assign diff    = shifted[WIDTH-1:0] - d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? DZ : CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      DZ:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      a_q      <= '0;
      d_q      <= '0;
      p_q      <= '0;
      dvd_q    <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      quotient <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
            dvd_q    <= divident;
            a_q      <= mag(divident, signed_mode);
            d_q      <= mag(divisor, signed_mode);
            p_q      <= '0;
            qneg     <= signed_mode & (divident[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg     <= signed_mode & divident[WIDTH-1];
            cnt      <= CW'(WIDTH - 1);
          end
        end
        CALC: begin
          p_q <= under ? shifted[WIDTH-1:0] : diff;
          a_q <= {a_q[WIDTH-2:0], ~under};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          quotient <= qneg ? -a_q : a_q;
          rem      <= rneg ? -p_q : p_q;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        DZ: begin
          quotient <= '1;
          rem      <= dvd_q;
          div_zero <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div_param.sv
// Directed bench for restoring_div_param: 8-bit and 16-bit instances, hand-computed results,
// latency, handshake, asynchronous reset and a 16-bit sweep against a behavioural reference.
module tb_restoring_div_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, sm8, busy8, done8, dz8;
  logic [7:0] dvd8, dvs8, q8, r8;

  logic        start16, sm16, busy16, done16, dz16;
  logic [15:0] dvd16, dvs16, q16, r16;

  int n_checks = 0;
  int n_fail   = 0;

  restoring_div_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .divident(dvd8), .divisor(dvs8), .quotient(q8), .rem(r8),
    .busy(busy8), .done(done8), .div_zero(dz8)
  );

  restoring_div_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .divident(dvd16), .divisor(dvs16), .quotient(q16), .rem(r16),
    .busy(busy16), .done(done16), .div_zero(dz16)
  );

  // lat = edges after the accepting edge until done is seen high
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm, output int lat);
    dvd8 = a; dvs8 = b; sm8 = sm; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sm, output int lat);
    dvd16 = a; dvs16 = b; sm16 = sm; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (done16 !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; dvd8 = '0; dvs8 = '0;
    start16 = 1'b0; sm16 = 1'b0; dvd16 = '0; dvs16 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (q8 !== 8'h00) begin n_fail++; $display("FAIL reset_quotient got %h want 00", q8); end
    n_checks++; if (r8 !== 8'h00) begin n_fail++; $display("FAIL reset_rem got %h want 00", r8); end
    n_checks++; if ({busy8, done8, dz8} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy8, done8, dz8}); end
    n_checks++; if ({busy16, done16, dz16} !== 3'b000) begin n_fail++; $display("FAIL reset_flags16 got %b want 000", {busy16, done16, dz16}); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    logic [7:0] va[5] = '{8'd15, 8'd16, 8'd239, 8'd255, 8'h80};
    logic [7:0] vb[5] = '{8'd4,  8'd2,  8'd8,   8'd1,   8'hFF};
    logic [7:0] eq[5] = '{8'd3,  8'd8,  8'd29,  8'd255, 8'd0};
    logic [7:0] er[5] = '{8'd3,  8'd0,  8'd7,   8'd0,   8'h80};
    int lat;
    for (int i = 0; i < 5; i++) begin
      op8(va[i], vb[i], 1'b0, lat);
      // 8 iterations plus FIX: done is visible 9 edges after acceptance, 10 counting the accept edge
      n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL unsigned_latency[%0d] got %0d want 9", i, lat); end
      n_checks++; if (q8 !== eq[i]) begin n_fail++; $display("FAIL unsigned_quotient[%0d] got %0d want %0d", i, q8, eq[i]); end
      n_checks++; if (r8 !== er[i]) begin n_fail++; $display("FAIL unsigned_rem[%0d] got %0d want %0d", i, r8, er[i]); end
      n_checks++; if (dz8 !== 1'b0) begin n_fail++; $display("FAIL unsigned_dz[%0d] got %b want 0", i, dz8); end
      @(posedge clk); #1;
      n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL done_single_cycle[%0d] got %b want 0", i, done8); end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    op8(8'd77, 8'd0, 1'b0, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dz_latency got %0d want 1", lat); end
    n_checks++; if (q8 !== 8'hFF) begin n_fail++; $display("FAIL dz_quotient got %h want ff", q8); end
    n_checks++; if (r8 !== 8'd77) begin n_fail++; $display("FAIL dz_rem got %0d want 77", r8); end
    n_checks++; if (dz8 !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", dz8); end
    @(posedge clk); #1;
    op8(8'h90, 8'h00, 1'b1, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dz_signed_latency got %0d want 1", lat); end
    n_checks++; if (q8 !== 8'hFF) begin n_fail++; $display("FAIL dz_signed_quotient got %h want ff", q8); end
    n_checks++; if (r8 !== 8'h90) begin n_fail++; $display("FAIL dz_signed_rem got %h want 90", r8); end
    n_checks++; if (dz8 !== 1'b1) begin n_fail++; $display("FAIL dz_signed_flag got %b want 1", dz8); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    logic [7:0] va[4] = '{8'hF9, 8'h07, 8'h80, 8'h80};
    logic [7:0] vb[4] = '{8'h02, 8'hFE, 8'hFF, 8'h03};
    logic [7:0] eq[4] = '{8'hFD, 8'hFD, 8'h80, 8'hD6};
    logic [7:0] er[4] = '{8'hFF, 8'h01, 8'h00, 8'hFE};
    int lat;
    for (int i = 0; i < 4; i++) begin
      op8(va[i], vb[i], 1'b1, lat);
      n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL signed_latency[%0d] got %0d want 9", i, lat); end
      n_checks++; if (q8 !== eq[i]) begin n_fail++; $display("FAIL signed_quotient[%0d] got %h want %h", i, q8, eq[i]); end
      n_checks++; if (r8 !== er[i]) begin n_fail++; $display("FAIL signed_rem[%0d] got %h want %h", i, r8, er[i]); end
      n_checks++; if (dz8 !== 1'b0) begin n_fail++; $display("FAIL signed_dz[%0d] got %b want 0", i, dz8); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    dvd8 = 8'd100; dvs8 = 8'd7; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    dvd8 = 8'd200; dvs8 = 8'd3; sm8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL busy_after_ignored_start got %b want 1", busy8); end
    lat = 4;
    while (done8 !== 1'b1 && lat < 40) begin
      n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL busy_held got %b want 1 at edge %0d", busy8, lat); end
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL ignored_start_latency got %0d want 9", lat); end
    n_checks++; if (q8 !== 8'd14) begin n_fail++; $display("FAIL ignored_start_quotient got %0d want 14", q8); end
    n_checks++; if (r8 !== 8'd2) begin n_fail++; $display("FAIL ignored_start_rem got %0d want 2", r8); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL busy_at_done got %b want 0", busy8); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    op8(8'd200, 8'd9, 1'b0, lat);
    n_checks++; if (q8 !== 8'd22 || r8 !== 8'd2) begin n_fail++; $display("FAIL b2b_first got %0d r %0d want 22 r 2", q8, r8); end
    // done is high now: present the next request in the same cycle
    op8(8'd50, 8'd6, 1'b0, lat);
    n_checks++; if (lat + 1 !== 10) begin n_fail++; $display("FAIL b2b_done_spacing got %0d want 10", lat + 1); end
    n_checks++; if (q8 !== 8'd8 || r8 !== 8'd2) begin n_fail++; $display("FAIL b2b_second got %0d r %0d want 8 r 2", q8, r8); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int seen;
    dvd8 = 8'd255; dvs8 = 8'd3; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    n_checks++; if (q8 !== 8'h00) begin n_fail++; $display("FAIL midreset_quotient got %h want 00", q8); end
    n_checks++; if (r8 !== 8'h00) begin n_fail++; $display("FAIL midreset_rem got %h want 00", r8); end
    n_checks++; if ({busy8, done8, dz8} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags got %b want 000", {busy8, done8, dz8}); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abandoned_op_activity got %0d cycles want 0", seen); end
    op8(8'd100, 8'd7, 1'b0, lat);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL post_reset_latency got %0d want 9", lat); end
    n_checks++; if (q8 !== 8'd14 || r8 !== 8'd2) begin n_fail++; $display("FAIL post_reset_result got %0d r %0d want 14 r 2", q8, r8); end
    @(posedge clk); #1;
  endtask

  task automatic test_width16();
    int lat;
    logic [15:0] a, b, eq, er;
    logic sm, edz;
    int sa, sb;
    op16(16'd65535, 16'd255, 1'b0, lat);
    // 16 iterations plus FIX: 17 edges after acceptance, 18 counting the accept edge
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL w16_latency got %0d want 17", lat); end
    n_checks++; if (q16 !== 16'd257 || r16 !== 16'd0) begin n_fail++; $display("FAIL w16_result got %0d r %0d want 257 r 0", q16, r16); end
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom); sm = 1'($urandom);
      if (i % 50 == 7)  b = 16'h0000;
      if (i % 37 == 5)  a = 16'h8000;
      if (i % 41 == 3)  b = 16'hFFFF;
      case (i)
        0: begin a = 16'h8000; b = 16'hFFFF; sm = 1'b1; end
        1: begin a = 16'h8000; b = 16'h0000; sm = 1'b1; end
        2: begin a = 16'h1234; b = 16'h0000; sm = 1'b0; end
        3: begin a = 16'h8000; b = 16'h0003; sm = 1'b1; end
        4: begin a = 16'h8000; b = 16'h8000; sm = 1'b0; end
        5: begin a = 16'h7FFF; b = 16'h8000; sm = 1'b1; end
        default: ;
      endcase
      if (b == 16'h0000) begin
        eq = 16'hFFFF; er = a; edz = 1'b1;
      end else if (sm) begin
        sa = $signed(a); sb = $signed(b);
        eq = 16'(sa / sb); er = 16'(sa % sb); edz = 1'b0;
      end else begin
        eq = a / b; er = a % b; edz = 1'b0;
      end
      op16(a, b, sm, lat);
      n_checks++; if (lat !== (edz ? 1 : 17)) begin n_fail++; $display("FAIL sweep_latency[%0d] got %0d want %0d", i, lat, edz ? 1 : 17); end
      n_checks++; if (q16 !== eq) begin n_fail++; $display("FAIL sweep_quotient[%0d] a=%h b=%h s=%b got %h want %h", i, a, b, sm, q16, eq); end
      n_checks++; if (r16 !== er) begin n_fail++; $display("FAIL sweep_rem[%0d] a=%h b=%h s=%b got %h want %h", i, a, b, sm, r16, er); end
      n_checks++; if (dz16 !== edz) begin n_fail++; $display("FAIL sweep_dz[%0d] got %b want %b", i, dz16, edz); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_signed();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_width16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
